// File: rtl/mult_booth.sv
// Sequential signed WIDTH x WIDTH radix-2 Booth multiplier for the MULT instruction.
// Optional feature: define MULT_ZERO_BYPASS_EN to finish at once when either operand is zero.
module mult_booth #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             mult_control,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             mult_end,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   step_sum;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH-1:0] q_sh;
  logic             zero_op;

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (a_in == '0) || (b_in == '0);
`else
  assign zero_op = 1'b0;
`endif

  // One Booth step: recode {Q[0], q_m1}, add/subtract M, then arithmetic shift {ACC, Q, q_m1}.
  always_comb begin
    case ({q_q[0], qm1_q})
      2'b10:   step_sum = acc_q - m_q;
      2'b01:   step_sum = acc_q + m_q;
      default: step_sum = acc_q;
    endcase
    acc_sh = {step_sum[WIDTH], step_sum[WIDTH:1]};
    q_sh   = {step_sum[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (mult_control) begin
          if (zero_op) begin
            hi_d    = '0;
            lo_d    = '0;
            state_d = S_DONE;
          end else begin
            m_d     = {a_in[WIDTH-1], a_in};
            q_d     = b_in;
            acc_d   = '0;
            qm1_d   = 1'b0;
            count_d = '0;
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d   = acc_sh;
        q_d     = q_sh;
        qm1_d   = q_q[0];
        count_d = count_q + CW'(1);
        if (count_q == LAST_STEP) begin
          hi_d    = acc_sh[WIDTH-1:0];
          lo_d    = q_sh;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign mult_end = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_booth.sv
// Self-checking bench for mult_booth: vector table of signed products plus
// hand-written sequences for operand capture, ignored restarts and mid-run reset.
module tb_mult_booth;

  logic        clk;
  logic        reset_in;
  logic        mult_control;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        mult_end;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mult_booth #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset_in     (reset_in),
    .mult_control (mult_control),
    .a_in         (a_in),
    .b_in         (b_in),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .mult_end     (mult_end),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start at edge 0, wait (bounded) for mult_end, then check product and the return to IDLE.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input string nm);
    int lat;
    int exp_lat;
    exp_lat = 32;
`ifdef MULT_ZERO_BYPASS_EN
    if (a == 32'h0 || b == 32'h0) exp_lat = 0;
`endif
    lat = -1;
    a_in = a;
    b_in = b;
    mult_control = 1'b1;
    tick();
    mult_control = 1'b0;
    if (mult_end) lat = 0;
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      tick();
      if (mult_end) lat = i;
    end
    check({nm, " latency"}, 64'(lat), 64'(exp_lat));
    if (lat >= 0) begin
      check({nm, " hi"}, 64'(hi_out), 64'(eh));
      check({nm, " lo"}, 64'(lo_out), 64'(el));
      check({nm, " busy_done"}, 64'(busy), 64'(1));
      tick();
      check({nm, " end_falls"}, 64'(mult_end), 64'(0));
      check({nm, " busy_falls"}, 64'(busy), 64'(0));
    end
  endtask

  vec_t vecs[11];
  int   busy_cnt;
  int   end_cnt;
  int   end_edge;

  initial begin
    vecs[0]  = '{32'd3,         32'd5,         32'h00000000, 32'h0000000F};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[2]  = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
    vecs[4]  = '{32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
    vecs[5]  = '{32'd6,         32'd7,         32'h00000000, 32'h0000002A};
    vecs[6]  = '{32'hFFFFFFFD, 32'd5,         32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[7]  = '{32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[8]  = '{32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    vecs[9]  = '{32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 32'h80000000};
    vecs[10] = '{32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

    reset_in = 1'b1;
    mult_control = 1'b0;
    a_in = '0;
    b_in = '0;
    repeat (3) tick();
    reset_in = 1'b0;
    check("reset hi", 64'(hi_out), 64'(0));
    check("reset lo", 64'(lo_out), 64'(0));
    check("reset mult_end", 64'(mult_end), 64'(0));
    check("reset busy", 64'(busy), 64'(0));

    for (int i = 0; i < 11; i++)
      do_mult(vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    // Operand changes and a second start request during RUN must be ignored.
    busy_cnt = 0;
    end_cnt  = 0;
    end_edge = -1;
    a_in = 32'h7FFFFFFF;
    b_in = 32'hFFFFFFFF;
    mult_control = 1'b1;
    tick();
    mult_control = 1'b0;
    if (busy) busy_cnt++;
    for (int i = 1; i <= 45; i++) begin
      tick();
      if (i == 1) check("hold prev product", {hi_out, lo_out}, 64'h00000001_00000000);
      if (i == 5) begin
        mult_control = 1'b1;
        a_in = 32'd5;
        b_in = 32'd5;
      end
      if (i == 6) mult_control = 1'b0;
      if (busy) busy_cnt++;
      if (mult_end) begin
        end_cnt++;
        if (end_edge < 0) end_edge = i;
      end
    end
    check("ignore busy cycles", 64'(busy_cnt), 64'(33));
    check("ignore end count", 64'(end_cnt), 64'(1));
    check("ignore end edge", 64'(end_edge), 64'(32));
    check("ignore hi", 64'(hi_out), 64'hFFFFFFFF);
    check("ignore lo", 64'(lo_out), 64'h80000001);

    // Reset at edge 10 of a 6x7 run discards it and clears the held product.
    a_in = 32'd6;
    b_in = 32'd7;
    mult_control = 1'b1;
    tick();
    mult_control = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    reset_in = 1'b1;
    tick();
    reset_in = 1'b0;
    check("midrst busy", 64'(busy), 64'(0));
    check("midrst hi", 64'(hi_out), 64'(0));
    check("midrst lo", 64'(lo_out), 64'(0));
    end_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mult_end || busy) end_cnt++;
    end
    check("midrst quiet", 64'(end_cnt), 64'(0));
    do_mult(32'd6, 32'd7, 32'h0, 32'h2A, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
